// File: rtl/mem_access_unit_if.sv
// Bundle of the MEM-stage pipeline controls and the data-memory req/ack port.
// The master modport is the access unit; the slave modport is the pipeline/memory side.
interface mem_access_unit_if;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [1:0]  MemSize_in;
  logic        MemSign_in;
  logic [31:0] ALUResult_in;
  logic [31:0] WriteData_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] MemData_out;
  logic        MEM_Stall;
  logic        MEM_Flush;
  logic        AlignErr;
  logic        BusErr;

  modport master (
    input  MemRead_in, MemWrite_in, MemSize_in, MemSign_in, ALUResult_in, WriteData_in,
    input  dmem_ack, dmem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output MemData_out, MEM_Stall, MEM_Flush, AlignErr, BusErr
  );

  modport slave (
    output MemRead_in, MemWrite_in, MemSize_in, MemSign_in, ALUResult_in, WriteData_in,
    output dmem_ack, dmem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  MemData_out, MEM_Stall, MEM_Flush, AlignErr, BusErr
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: issues req/ack accesses, stalls the pipeline,
// formats load data and flags misaligned or timed-out accesses.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_rdata_q;
  logic [7:0]  r_wait_cnt;
  logic        r_berr_q;

  logic        w_access, w_wr, w_half, w_word, w_mis, w_req, w_timeout;
  logic [1:0]  w_a;
  logic [3:0]  w_store_be;
  logic [31:0] w_store_wd, w_fmt;
  logic [7:0]  w_byte;
  logic [15:0] w_hword;

  assign w_a      = bus.ALUResult_in[1:0];
  assign w_access = bus.MemRead_in | bus.MemWrite_in;
  assign w_wr     = bus.MemWrite_in;
  assign w_half   = (bus.MemSize_in == 2'b01);
  assign w_word   = bus.MemSize_in[1];
  assign w_mis    = w_access & ((w_half & w_a[0]) | (w_word & (w_a != 2'b00)));
  assign w_timeout = (r_wait_cnt == 8'(TIMEOUT));

  // Store lane steering; size 11 falls into the word case.
  always_comb begin
    w_store_be = 4'b1111;
    w_store_wd = bus.WriteData_in;
    if (bus.MemSize_in == 2'b00) begin
      w_store_be = 4'b0001 << w_a;
      w_store_wd = {4{bus.WriteData_in[7:0]}};
    end else if (w_half) begin
      w_store_be = w_a[1] ? 4'b1100 : 4'b0011;
      w_store_wd = {2{bus.WriteData_in[15:0]}};
    end
  end

  always_comb begin
    w_byte = r_rdata_q[7:0];
    case (w_a)
      2'd1:    w_byte = r_rdata_q[15:8];
      2'd2:    w_byte = r_rdata_q[23:16];
      2'd3:    w_byte = r_rdata_q[31:24];
      default: w_byte = r_rdata_q[7:0];
    endcase
    w_hword = w_a[1] ? r_rdata_q[31:16] : r_rdata_q[15:0];
    if (bus.MemSize_in == 2'b00)
      w_fmt = {{24{bus.MemSign_in & w_byte[7]}}, w_byte};
    else if (w_half)
      w_fmt = {{16{bus.MemSign_in & w_hword[15]}}, w_hword};
    else
      w_fmt = r_rdata_q;
  end

  // Outputs are forced idle while reset is held so a live instruction cannot request.
  always_comb begin
    w_state_nxt     = r_state;
    w_req           = 1'b0;
    bus.MEM_Stall   = 1'b0;
    bus.MEM_Flush   = 1'b0;
    bus.AlignErr    = 1'b0;
    bus.BusErr      = 1'b0;
    bus.MemData_out = 32'h0;
    if (rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_mis) begin
            bus.AlignErr  = 1'b1;
            bus.MEM_Flush = 1'b1;
          end else if (w_access) begin
            w_req         = 1'b1;
            bus.MEM_Stall = 1'b1;
            w_state_nxt   = bus.dmem_ack ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          w_req         = 1'b1;
          bus.MEM_Stall = 1'b1;
          if (bus.dmem_ack || w_timeout) w_state_nxt = S_DONE;
        end
        S_DONE: begin
          w_state_nxt     = S_IDLE;
          bus.BusErr      = r_berr_q;
          bus.MEM_Flush   = r_berr_q;
          bus.MemData_out = w_wr ? 32'h0 : w_fmt;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.dmem_req   = w_req;
  assign bus.dmem_we    = w_req & w_wr;
  assign bus.dmem_addr  = w_req ? {bus.ALUResult_in[31:2], 2'b00} : 32'h0;
  assign bus.dmem_be    = w_req ? (w_wr ? w_store_be : 4'b1111) : 4'b0000;
  assign bus.dmem_wdata = w_req ? w_store_wd : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rdata_q  <= 32'h0;
      r_wait_cnt <= 8'h0;
      r_berr_q   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (bus.dmem_ack) r_rdata_q  <= bus.dmem_rdata;
            else              r_wait_cnt <= 8'd1;
          end
        end
        S_WAIT: begin
          // Ack beats a coincident timeout.
          if (bus.dmem_ack) begin
            r_rdata_q <= bus.dmem_rdata;
          end else if (w_timeout) begin
            r_berr_q  <= 1'b1;
            r_rdata_q <= 32'h0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_berr_q   <= 1'b0;
          r_wait_cnt <= 8'h0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a transaction-level expectation model.
module tb_mem_access_unit;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  logic        chk_en = 1'b0;
  logic        exp_req, exp_stall, exp_flush, exp_aerr, exp_berr, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_md;
  logic [3:0]  exp_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
  endtask

  function automatic logic [3:0] m_be(input bit wr, input logic [1:0] sz, input logic [31:0] a);
    int unsigned off = a % 4;
    if (!wr) return 4'hF;
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << (off - off % 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd % 256) * 32'h01010101;
    if (sz == 2'd1) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_fmt(input logic [31:0] rd, input logic [31:0] a,
                                        input logic [1:0] sz, input bit sg);
    int unsigned off = a % 4;
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * off)) % 256;
      if (sg && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (8 * (off - off % 2))) % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic set_idle_exp();
    exp_req = 0; exp_stall = 0; exp_flush = 0; exp_aerr = 0; exp_berr = 0;
    exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0; exp_md = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dmem_req", 32'(bus.dmem_req), 32'(exp_req));
      chk("MEM_Stall", 32'(bus.MEM_Stall), 32'(exp_stall));
      chk("MEM_Flush", 32'(bus.MEM_Flush), 32'(exp_flush));
      chk("AlignErr", 32'(bus.AlignErr), 32'(exp_aerr));
      chk("BusErr", 32'(bus.BusErr), 32'(exp_berr));
      chk("MemData_out", bus.MemData_out, exp_md);
      chk("dmem_we", 32'(bus.dmem_we), 32'(exp_we));
      chk("dmem_addr", bus.dmem_addr, exp_addr);
      chk("dmem_be", 32'(bus.dmem_be), 32'(exp_be));
      if (exp_we) chk("dmem_wdata", bus.dmem_wdata, exp_wdata);
    end
  end

  // d = ack delay in wait cycles; d > T means the memory never answers.
  task automatic run_txn(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                         input int d, input bit use_lit, input logic [31:0] lit_md,
                         input logic [3:0] lit_be);
    bit acc, mis, tmo;
    int n_stall;
    bus.MemRead_in = rd; bus.MemWrite_in = wr; bus.MemSize_in = sz; bus.MemSign_in = sg;
    bus.ALUResult_in = a; bus.WriteData_in = wd;
    acc = rd | wr;
    mis = acc && ((sz == 2'd1 && a % 2 != 0) || (sz >= 2'd2 && a % 4 != 0));
    set_idle_exp();
    if (!acc || mis) begin
      exp_aerr = mis; exp_flush = mis;
      bus.dmem_ack = 1'($urandom_range(0, 1)); bus.dmem_rdata = $urandom;
      step();
    end else begin
      tmo = (d > T);
      n_stall = tmo ? T + 1 : d + 1;
      for (int k = 0; k < n_stall; k++) begin
        exp_req = 1; exp_stall = 1; exp_we = wr; exp_addr = a - a % 4;
        exp_be = use_lit ? lit_be : m_be(wr, sz, a);
        exp_wdata = m_wd(sz, wd);
        bus.dmem_ack = (k == d);
        bus.dmem_rdata = (k == d) ? rdata : $urandom;
        step();
      end
      set_idle_exp();
      exp_berr = tmo; exp_flush = tmo;
      if (!tmo && !wr) exp_md = use_lit ? lit_md : m_fmt(rdata, a, sz, sg);
      bus.dmem_ack = 1'($urandom_range(0, 1)); bus.dmem_rdata = $urandom;
      step();
    end
  endtask

  initial begin
    bus.MemRead_in = 0; bus.MemWrite_in = 0; bus.MemSize_in = 0; bus.MemSign_in = 0;
    bus.ALUResult_in = 0; bus.WriteData_in = 0; bus.dmem_ack = 0; bus.dmem_rdata = 0;
    set_idle_exp();
    #12;
    chk("rst dmem_req", 32'(bus.dmem_req), 0);
    chk("rst MEM_Stall", 32'(bus.MEM_Stall), 0);
    chk("rst MemData_out", bus.MemData_out, 0);
    step();
    rst = 1;
    // Park a load in WAIT, then pull reset asynchronously mid-cycle.
    bus.MemRead_in = 1; bus.MemSize_in = 2'd2; bus.ALUResult_in = 32'h100;
    step();
    chk("wait dmem_req", 32'(bus.dmem_req), 1);
    #2 rst = 0;
    #1;
    chk("async rst dmem_req", 32'(bus.dmem_req), 0);
    chk("async rst MEM_Stall", 32'(bus.MEM_Stall), 0);
    chk("async rst dmem_be", 32'(bus.dmem_be), 0);
    chk("async rst dmem_addr", bus.dmem_addr, 0);
    chk("async rst MemData_out", bus.MemData_out, 0);
    step();
    bus.MemRead_in = 0; bus.dmem_ack = 1; bus.dmem_rdata = 32'h12345678;
    rst = 1;
    chk_en = 1;
    step(); step();
    chk_en = 0;
    #1 chk_en = 1;

    // rd wr sz sg addr wd rdata d lit md be
    run_txn(1, 0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 4'hF);
    run_txn(1, 0, 2'd0, 1, 32'h103, 0, 32'h80112233, 3, 1, 32'hFFFFFF80, 4'hF);
    run_txn(1, 0, 2'd1, 0, 32'h102, 0, 32'h80112233, 1, 1, 32'h00008011, 4'hF);
    run_txn(0, 1, 2'd0, 0, 32'h201, 32'h000000AB, 0, 2, 1, 32'h0, 4'b0010);
    run_txn(0, 1, 2'd1, 0, 32'h202, 32'h0000CAFE, 0, 0, 1, 32'h0, 4'b1100);
    run_txn(1, 0, 2'd2, 0, 32'h102, 0, 32'h11111111, 0, 0, 0, 0);
    run_txn(1, 0, 2'd2, 0, 32'h300, 0, 32'hA5A5A5A5, T + 2, 1, 32'h0, 4'hF);
    run_txn(1, 0, 2'd2, 0, 32'h304, 0, 32'h0BADF00D, T, 1, 32'h0BADF00D, 4'hF);
    run_txn(1, 1, 2'd0, 1, 32'h402, 32'h0000007F, 32'hFFFFFFFF, 1, 1, 32'h0, 4'b0100);
    run_txn(1, 0, 2'd3, 0, 32'h500, 0, 32'h87654321, 0, 1, 32'h87654321, 4'hF);

    for (int i = 0; i < 400; i++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              $urandom_range(0, T + 2), 0, 0, 0);
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns the MEM-stage control and address into a req/ack transaction on the data-memory port. It stalls the pipeline until the access completes and formats load data (byte/half/word, signed/unsigned) into the value latched by MEM/WB. It also detects misaligned and timed-out accesses and flushes the faulting instruction out of MEM/WB.

## Interface
- TIMEOUT, default 255: maximum cycles spent in WAIT before a bus error is declared (1..255).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- MemRead_in  in  1  load in MEM stage.
- MemWrite_in  in  1  store in MEM stage.
- MemSize_in  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- MemSign_in  in  1  1 = sign-extend load, 0 = zero-extend.
- ALUResult_in  in  32  effective byte address.
- WriteData_in  in  32  store data; low byte/half used for sub-word stores.
- dmem_req  out  1  access request, held until ack or timeout.
- dmem_we  out  1  1 = write; valid while dmem_req.
- dmem_addr  out  32  {ALUResult_in[31:2], 2'b00}.
- dmem_be  out  4  byte enables, bit i = byte lane i, little-endian.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  memory completion, sampled on rising clk.
- dmem_rdata  in  32  read word; valid in the cycle dmem_ack is high.
- MemData_out  out  32  formatted load result, feeds MEM/WB MemData input.
- MEM_Stall  out  1  hold EX/MEM, MEM/WB and upstream stages.
- MEM_Flush  out  1  bubble MEM/WB this cycle.
- AlignErr  out  1  one-cycle misaligned-access flag.
- BusErr  out  1  one-cycle timeout flag.

## Operation
- States: IDLE, WAIT, DONE. Registers: state, rdata_q[31:0], wait_cnt[7:0], berr_q.
- access = MemRead_in | MemWrite_in. If both are set, the access is a write.
- misaligned = access & ((half & addr[0]) | (word & addr[1:0]!=0)).
- IDLE:
  - no access: all outputs idle, MemData_out = 0.
  - misaligned: no request; AlignErr = 1 and MEM_Flush = 1 combinationally; MEM_Stall = 0; remain IDLE.
  - aligned access: dmem_req = 1, MEM_Stall = 1. If dmem_ack is high at the edge, capture rdata_q and go to DONE; otherwise go to WAIT with wait_cnt = 1.
- WAIT: dmem_req = 1, MEM_Stall = 1.
  - ack: capture rdata_q, go to DONE.
  - no ack and wait_cnt == TIMEOUT: set berr_q, rdata_q = 0, go to DONE.
  - otherwise wait_cnt++.
- DONE: dmem_req = 0, MEM_Stall = 0, MemData_out = format(rdata_q); BusErr = MEM_Flush = berr_q. Always go to IDLE next edge; clear berr_q and wait_cnt.
- Inputs are held stable by the stalled EX/MEM register through IDLE→WAIT→DONE. Formatting uses the live ALUResult_in[1:0], MemSize_in and MemSign_in.
- Store lanes:
  - byte: be = 4'b0001 << addr[1:0], wdata = {4{WD[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{WD[15:0]}}.
  - word: be = 4'b1111, wdata = WD.
  - Loads drive be = 4'b1111, dmem_we = 0.
- Load format: select byte lane addr[1:0] or half lane addr[1], then sign- or zero-extend to 32 bits. Stores return MemData_out = 0.
- dmem_ack outside IDLE-with-request or WAIT is ignored.

## Timing
- Reset values: state IDLE, rdata_q 0, wait_cnt 0, berr_q 0. All outputs 0: dmem_req, dmem_we, dmem_be, dmem_addr/wdata pass-through of current inputs gated to 0 when idle, MemData_out, MEM_Stall, MEM_Flush, AlignErr, BusErr.
- Reset asserted mid-access: dmem_req drops immediately (asynchronous); a late ack after release in IDLE with no access is ignored.
- Memory instruction with ack in the first request cycle: 1 stall cycle, result in cycle 2 (DONE). Ack after k wait cycles: k+1 stall cycles.
- Ack and timeout in the same cycle: ack wins, no BusErr.
- Non-memory and misaligned instructions: 0 stall cycles.
- dmem_req, MEM_Stall and AlignErr are combinational from state and inputs. MemData_out is combinational from rdata_q.

## Test plan
- Reset with rst = 0 while in WAIT → dmem_req = 0 in the same cycle, state IDLE, all outputs 0.
- LW at 0x100, ack in the first cycle, rdata 0xDEADBEEF → one stall cycle, then MemData_out = 0xDEADBEEF, MEM_Stall = 0.
- LB signed at 0x103, rdata 0x80112233, ack after 3 wait cycles → 4 stall cycles, MemData_out = 0xFFFFFF80. LHU at 0x102 with the same data → 0x00008011.
- SB at 0x201, WriteData 0x000000AB → dmem_we = 1, be = 0010, wdata = 0xABABABAB, addr = 0x200. SH at 0x202 → be = 1100.
- LW at 0x102 → no req, AlignErr = 1, MEM_Flush = 1, MEM_Stall = 0 for one cycle.
- TIMEOUT = 4, LW with no ack → 5 stall cycles, then DONE with BusErr = 1, MEM_Flush = 1, MemData_out = 0. Ack arriving exactly at the timeout cycle → normal completion, BusErr = 0.
